// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, quarter phases, transfer direction and byte slots.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BIT,
    ST_RX_ACK,
    ST_RX_BIT,
    ST_TX_NACK,
    ST_STOP
  } i2c_state_e;

  localparam logic [1:0] QTR_0 = 2'd0;
  localparam logic [1:0] QTR_1 = 2'd1;
  localparam logic [1:0] QTR_2 = 2'd2;
  localparam logic [1:0] QTR_3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam logic [1:0] BYTE_DEV  = 2'd0;
  localparam logic [1:0] BYTE_REG  = 2'd1;
  localparam logic [1:0] BYTE_DATA = 2'd2;

  localparam logic [2:0] BIT_MSB = 3'd7;

  // Address byte as it appears on the wire: 7-bit address followed by the R/W bit.
  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Divides the system clock into SCL quarter periods; held at quarter 0 while disabled.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] quarter_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;

  assign tick_o    = en_i && (cnt_q == LAST);
  assign quarter_o = qtr_q;

  // Count clk cycles within a quarter and advance the quarter index on each tick.
  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    if (!en_i) begin
      cnt_d = '0;
      qtr_d = 2'd0;
    end else if (tick_o) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      qtr_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Single-register I2C initiator: register write and register read (stop + restart) with ACK checking.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic       phase2_q, phase2_d;
  logic       err_q, err_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d, wdata_q, wdata_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic       busy_q, busy_d, done_q, done_d, ackerr_q, ackerr_d;
  logic       sda_meta_q, sda_sync_q;

  logic       tick;
  logic [1:0] quarter;
  logic       sample, qend;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en_i      (busy_q),
    .tick_o    (tick),
    .quarter_o (quarter)
  );

  assign sample  = tick && (quarter == QTR_2);
  assign qend    = tick && (quarter == QTR_3);
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ackerr_q;

  // Sequence the transaction slot by slot; every slot ends on the last cycle of quarter 3.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    phase2_d = phase2_q;
    err_d    = err_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ackerr_d = ackerr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_START;
          busy_d   = 1'b1;
          rw_d     = rw;
          dev_d    = dev_addr;
          reg_d    = reg_addr;
          wdata_d  = wdata;
          phase2_d = 1'b0;
          err_d    = 1'b0;
          byte_d   = BYTE_DEV;
        end
      end
      ST_START: begin
        if (qend) begin
          state_d = ST_TX_BIT;
          bit_d   = BIT_MSB;
          tx_d    = addr_byte(dev_q, phase2_q ? I2C_READ : I2C_WRITE);
        end
      end
      ST_TX_BIT: begin
        if (qend) begin
          if (bit_q == 3'd0) begin
            state_d = ST_RX_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      ST_RX_ACK: begin
        if (sample) begin
          err_d = err_q | sda_sync_q;
        end
        if (qend) begin
          if (err_q) begin
            state_d = ST_STOP;
          end else if (phase2_q) begin
            state_d = ST_RX_BIT;
            bit_d   = BIT_MSB;
          end else if (byte_q == BYTE_DEV) begin
            state_d = ST_TX_BIT;
            bit_d   = BIT_MSB;
            byte_d  = BYTE_REG;
            tx_d    = reg_q;
          end else if ((byte_q == BYTE_REG) && (rw_q == I2C_WRITE)) begin
            state_d = ST_TX_BIT;
            bit_d   = BIT_MSB;
            byte_d  = BYTE_DATA;
            tx_d    = wdata_q;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_RX_BIT: begin
        if (sample) begin
          rx_d = {rx_q[6:0], sda_sync_q};
        end
        if (qend) begin
          if (bit_q == 3'd0) begin
            state_d = ST_TX_NACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ST_TX_NACK: begin
        if (qend) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (qend) begin
          if ((rw_q == I2C_READ) && !phase2_q && !err_q) begin
            state_d  = ST_START;
            phase2_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            ackerr_d = err_q;
            if (phase2_q && !err_q) begin
              rdata_d = rx_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode the open-drain pull-low enables from the current slot and quarter.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      ST_START: begin
        sda_oe = (quarter == QTR_2) || (quarter == QTR_3);
        scl_oe = (quarter == QTR_3);
      end
      ST_TX_BIT: begin
        scl_oe = (quarter == QTR_0) || (quarter == QTR_1);
        sda_oe = ~tx_q[7];
      end
      ST_RX_ACK, ST_RX_BIT, ST_TX_NACK: begin
        scl_oe = (quarter == QTR_0) || (quarter == QTR_1);
      end
      ST_STOP: begin
        scl_oe = (quarter == QTR_0);
        sda_oe = (quarter == QTR_0) || (quarter == QTR_1);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  // State registers; reset drops to IDLE so both lines are released at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= 3'd0;
      byte_q   <= BYTE_DEV;
      phase2_q <= 1'b0;
      err_q    <= 1'b0;
      rw_q     <= I2C_WRITE;
      dev_q    <= 7'h00;
      reg_q    <= 8'h00;
      wdata_q  <= 8'h00;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ackerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      phase2_q <= phase2_d;
      err_q    <= err_d;
      rw_q     <= rw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ackerr_q <= ackerr_d;
    end
  end

  // Two-flop synchronizer for the asynchronous SDA pad; idles high like the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: bus decoder plus peripheral model, checked against a transaction-level model.
module tb_i2c_controller;

  localparam int CLK_DIV = 4;
  localparam int EV_S = 'h1000;
  localparam int EV_P = 'h2000;

  typedef struct {
    logic       rwV;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] rd;
    int         nackAt;
    logic       expErr;
    int         expCycles;
    logic [7:0] expRdata;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, ack_err, scl_oe, sda_oe;
  logic       perPull = 1'b0;
  wire        sdaLine = ~(sda_oe | perPull);

  int         assertCount = 0;
  int         failCount = 0;
  int         clearReq = 0;
  int         clearSeen = 0;
  int         cfgNackAt = 99;
  logic [7:0] cfgRdVal = 8'h00;
  int         evQ[$];
  int         expQ[$];

  i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rw       (rw),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_in   (sdaLine)
  );

  always #5 clk = ~clk;

  // Bus decoder and peripheral: logs START/STOP/byte events and drives ACKs and read data.
  initial begin : monitor
    logic       scl, sda, sclPrev, sdaPrev, lastAck, rdActive, firstByte;
    logic [7:0] shiftIn;
    int         bitCnt, byteCnt;
    sclPrev = 1'b1; sdaPrev = 1'b1; lastAck = 1'b1; rdActive = 1'b0; firstByte = 1'b0;
    shiftIn = 8'h00; bitCnt = 0; byteCnt = 0;
    forever begin
      @(negedge clk);
      scl = ~scl_oe;
      sda = sdaLine;
      if (clearReq != clearSeen) begin
        clearSeen = clearReq;
        evQ.delete();
        bitCnt = 0; byteCnt = 0; rdActive = 1'b0; firstByte = 1'b0; perPull = 1'b0;
      end else if (sclPrev && scl && sdaPrev && !sda) begin
        evQ.push_back(EV_S);
        bitCnt = 0; rdActive = 1'b0; firstByte = 1'b1;
      end else if (sclPrev && scl && !sdaPrev && sda) begin
        evQ.push_back(EV_P);
        bitCnt = 0; rdActive = 1'b0;
      end else if (!sclPrev && scl) begin
        bitCnt++;
        if (bitCnt <= 8) shiftIn = {shiftIn[6:0], sda};
        else if (bitCnt == 9) begin
          evQ.push_back({23'd0, sda, shiftIn});
          lastAck = sda;
        end
      end else if (sclPrev && !scl) begin
        if (bitCnt == 8) begin
          if (rdActive) perPull = 1'b0;
          else begin
            perPull = (byteCnt != cfgNackAt);
            byteCnt++;
          end
        end else if (bitCnt == 9) begin
          perPull = 1'b0;
          bitCnt = 0;
          if (rdActive) rdActive = 1'b0;
          else if (firstByte && shiftIn[0] && !lastAck) begin
            rdActive = 1'b1;
            perPull = ~cfgRdVal[7];
          end
          firstByte = 1'b0;
        end else if (rdActive && bitCnt >= 1 && bitCnt <= 7) begin
          perPull = ~cfgRdVal[7 - bitCnt];
        end
      end
      sclPrev = scl;
      sdaPrev = sda;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] d, input logic [7:0] rg, input logic [7:0] wd);
    @(negedge clk);
    rw = r; dev_addr = d; reg_addr = rg; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Transaction-level reference: appends the expected bus events and returns length in quarters.
  task automatic buildExpected(input logic r, input logic [6:0] d, input logic [7:0] rg, input logic [7:0] wd,
                               input logic [7:0] rd, input int na, output int quarters,
                               output logic err, output logic rdValid);
    logic [7:0] tx[$];
    int k;
    quarters = 0; err = 1'b0; rdValid = 1'b0; k = 0;
    tx.push_back({d, 1'b0});
    tx.push_back(rg);
    if (!r) tx.push_back(wd);
    expQ.push_back(EV_S); quarters += 4;
    foreach (tx[i]) begin
      if (!err) begin
        err = (k == na);
        expQ.push_back({23'd0, err, tx[i]});
        quarters += 36;
        k++;
      end
    end
    expQ.push_back(EV_P); quarters += 4;
    if (r && !err) begin
      expQ.push_back(EV_S); quarters += 4;
      err = (k == na);
      expQ.push_back({23'd0, err, d, 1'b1}); quarters += 36;
      if (!err) begin
        expQ.push_back({23'd0, 1'b1, rd}); quarters += 36;
        rdValid = 1'b1;
      end
      expQ.push_back(EV_P); quarters += 4;
    end
  endtask

  task automatic waitDone(output int cyc, output logic ok);
    cyc = 0; ok = 1'b0;
    while (cyc < 3000 && !ok) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic compareEvents(input string name);
    checkOutput({name, " event count"}, evQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < evQ.size(); i++)
      checkOutput($sformatf("%s event %0d", name, i), evQ[i], expQ[i]);
  endtask

  task automatic runTxn(input string name, input vec_t v);
    int q, cyc;
    logic e, rv, ok;
    clearReq++;
    cfgNackAt = v.nackAt;
    cfgRdVal = v.rd;
    repeat (2) @(negedge clk);
    expQ.delete();
    buildExpected(v.rwV, v.dev, v.rg, v.wd, v.rd, v.nackAt, q, e, rv);
    applyStimulus(v.rwV, v.dev, v.rg, v.wd);
    checkOutput({name, " busy rise"}, busy, 1);
    waitDone(cyc, ok);
    checkOutput({name, " done seen"}, ok, 1);
    checkOutput({name, " cycles"}, cyc, v.expCycles);
    checkOutput({name, " busy at done"}, busy, 0);
    checkOutput({name, " ack_err"}, ack_err, v.expErr);
    checkOutput({name, " rdata"}, rdata, v.expRdata);
    compareEvents(name);
    @(negedge clk);
    checkOutput({name, " done width"}, done, 0);
  endtask

  initial begin
    vec_t       vecs[8];
    vec_t       v;
    int         q, q2, cyc;
    logic       e, rv, ok;
    logic [7:0] expRdata;

    vecs[0] = '{1'b0, 7'h42, 8'h67, 8'h66, 8'h00, 99, 1'b0, 464, 8'h00};
    vecs[1] = '{1'b1, 7'h42, 8'h67, 8'h00, 8'hA5, 99, 1'b0, 640, 8'hA5};
    vecs[2] = '{1'b1, 7'h42, 8'h67, 8'h00, 8'h3C, 0,  1'b1, 176, 8'hA5};
    vecs[3] = '{1'b0, 7'h42, 8'h67, 8'h66, 8'h00, 1,  1'b1, 320, 8'hA5};
    vecs[4] = '{1'b1, 7'h42, 8'h67, 8'h00, 8'h11, 2,  1'b1, 496, 8'hA5};
    vecs[5] = '{1'b0, 7'h13, 8'hC4, 8'h81, 8'h00, 2,  1'b1, 464, 8'hA5};
    vecs[6] = '{1'b1, 7'h7F, 8'h00, 8'h00, 8'h00, 99, 1'b0, 640, 8'h00};
    vecs[7] = '{1'b1, 7'h00, 8'hFF, 8'h00, 8'hFF, 99, 1'b0, 640, 8'hFF};

    repeat (3) @(negedge clk);
    checkOutput("reset scl_oe", scl_oe, 0);
    checkOutput("reset sda_oe", sda_oe, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ack_err", ack_err, 0);
    checkOutput("reset rdata", rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", busy, 0);

    for (int i = 0; i < 8; i++) runTxn($sformatf("vec%0d", i), vecs[i]);
    expRdata = vecs[7].expRdata;

    for (int i = 0; i < 8; i++) begin
      v.rwV = 1'($urandom_range(0, 1));
      v.dev = 7'($urandom);
      v.rg = 8'($urandom);
      v.wd = 8'($urandom);
      v.rd = 8'($urandom);
      v.nackAt = int'($urandom_range(0, 5));
      expQ.delete();
      buildExpected(v.rwV, v.dev, v.rg, v.wd, v.rd, v.nackAt, q, e, rv);
      v.expCycles = q * CLK_DIV;
      v.expErr = e;
      v.expRdata = rv ? v.rd : expRdata;
      runTxn($sformatf("rand%0d", i), v);
      expRdata = v.expRdata;
    end

    // Back-to-back: a start mid-transaction is ignored, a start in the done cycle runs at once.
    clearReq++;
    cfgNackAt = 99;
    cfgRdVal = 8'h5A;
    repeat (2) @(negedge clk);
    expQ.delete();
    buildExpected(1'b0, 7'h11, 8'h22, 8'h33, 8'h00, 99, q, e, rv);
    buildExpected(1'b1, 7'h55, 8'h66, 8'h00, 8'h5A, 99, q2, e, rv);
    applyStimulus(1'b0, 7'h11, 8'h22, 8'h33);
    checkOutput("b2b busy rise", busy, 1);
    cyc = 0;
    repeat (100) begin @(negedge clk); cyc++; end
    rw = 1'b1; dev_addr = 7'h55; reg_addr = 8'h66; wdata = 8'h00; start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    ok = 1'b0;
    while (cyc < 3000 && !ok) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1'b1;
    end
    checkOutput("b2b first done", ok, 1);
    checkOutput("b2b first cycles", cyc, q * CLK_DIV);
    checkOutput("b2b first ack_err", ack_err, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b no gap busy", busy, 1);
    checkOutput("b2b no gap done", done, 0);
    waitDone(cyc, ok);
    checkOutput("b2b second done", ok, 1);
    checkOutput("b2b second cycles", cyc, q2 * CLK_DIV);
    checkOutput("b2b rdata", rdata, 8'h5A);
    checkOutput("b2b ack_err", ack_err, 0);
    compareEvents("b2b");

    // Reset during the register-address byte releases both lines asynchronously.
    clearReq++;
    cfgNackAt = 99;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 7'h42, 8'h67, 8'h66);
    repeat (208) @(negedge clk);
    checkOutput("pre-reset scl_oe", scl_oe, 1);
    checkOutput("pre-reset sda_oe", sda_oe, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid-reset scl_oe", scl_oe, 0);
    checkOutput("mid-reset sda_oe", sda_oe, 0);
    checkOutput("mid-reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    v = vecs[0];
    v.expRdata = 8'h00;
    runTxn("post-reset", v);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
